// File: rtl/vga_pkg.sv
// ---------------------------------------------------------------------------
// vga_pkg
//   Shared constants and types for the canvas read/scan-out path:
//   640x480@60 timing, canvas window placement, and the 8-entry colour
//   palette used to turn a 3-bit colour code into 4:4:4 RGB.
// ---------------------------------------------------------------------------
package vga_pkg;

  // Horizontal timing, in pixels.
  localparam logic [9:0] H_ACTIVE     = 10'd640;
  localparam logic [9:0] H_FP         = 10'd16;
  localparam logic [9:0] H_SYNC       = 10'd96;
  localparam logic [9:0] H_BP         = 10'd48;
  localparam logic [9:0] H_TOTAL      = H_ACTIVE + H_FP + H_SYNC + H_BP;  // 800
  localparam logic [9:0] H_SYNC_START = H_ACTIVE + H_FP;                  // 656
  localparam logic [9:0] H_SYNC_END   = H_SYNC_START + H_SYNC;            // 752

  // Vertical timing, in lines.
  localparam logic [9:0] V_ACTIVE     = 10'd480;
  localparam logic [9:0] V_FP         = 10'd10;
  localparam logic [9:0] V_SYNC       = 10'd2;
  localparam logic [9:0] V_BP         = 10'd33;
  localparam logic [9:0] V_TOTAL      = V_ACTIVE + V_FP + V_SYNC + V_BP;  // 525
  localparam logic [9:0] V_SYNC_START = V_ACTIVE + V_FP;                  // 490
  localparam logic [9:0] V_SYNC_END   = V_SYNC_START + V_SYNC;            // 492

  // Canvas window on screen.
  localparam logic [9:0] CANVAS_X0 = 10'd220;
  localparam logic [9:0] CANVAS_Y0 = 10'd140;
  localparam logic [9:0] CANVAS_W  = 10'd200;
  localparam logic [9:0] CANVAS_H  = 10'd200;

  // Palette index shown in the active area around the canvas.
  localparam logic [2:0] BORDER_CODE = 3'b000;

  typedef struct packed {
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;
  } rgb_t;

  // black, red, green, blue, yellow, cyan, magenta, white
  localparam rgb_t PALETTE [8] = '{
    rgb_t'(12'h000), rgb_t'(12'hF00), rgb_t'(12'h0F0), rgb_t'(12'h00F),
    rgb_t'(12'hFF0), rgb_t'(12'h0FF), rgb_t'(12'hF0F), rgb_t'(12'hFFF)
  };

endpackage

// File: rtl/vga_timing.sv
// ---------------------------------------------------------------------------
// vga_timing
//   Free-running 800x525 pixel/line counters and the raw (unregistered)
//   timing flags derived from them.
//   clk       : pixel clock
//   reset     : asynchronous, active-high; counters return to (0,0)
//   hcnt/vcnt : current pixel column / line
//   active    : counter position lies in the 640x480 visible area
//   hsync_raw : active-low horizontal sync for the current position
//   vsync_raw : active-low vertical sync for the current position
//   sof       : high at position (0,0)
// ---------------------------------------------------------------------------
module vga_timing
  import vga_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  output logic [9:0] hcnt,
  output logic [9:0] vcnt,
  output logic       active,
  output logic       hsync_raw,
  output logic       vsync_raw,
  output logic       sof
);

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of its neighbours, independent of block ordering.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hcnt <= '0;
      vcnt <= '0;
    end else if (hcnt == H_TOTAL - 10'd1) begin
      hcnt <= '0;
      vcnt <= (vcnt == V_TOTAL - 10'd1) ? '0 : vcnt + 10'd1;
    end else begin
      hcnt <= hcnt + 10'd1;
    end
  end

  assign active    = (hcnt < H_ACTIVE) && (vcnt < V_ACTIVE);
  assign hsync_raw = !((hcnt >= H_SYNC_START) && (hcnt < H_SYNC_END));
  assign vsync_raw = !((vcnt >= V_SYNC_START) && (vcnt < V_SYNC_END));
  assign sof       = (hcnt == '0) && (vcnt == '0);

endmodule

// File: rtl/vga_canvas_reader.sv
// ---------------------------------------------------------------------------
// vga_canvas_reader
//   Scans the 200x200 canvas out of the pixel store onto 640x480@60 VGA.
//   Stage 0 presents the canvas-relative read address, stage 1 receives the
//   store's registered colour code, stage 2 registers every pin.
//   clk         : pixel clock
//   reset       : asynchronous, active-high
//   colorCode   : store read data, valid the cycle after rx/ry
//   rx, ry      : canvas-relative read address (0 outside the canvas)
//   hsync/vsync : active-low syncs
//   r, g, b     : 4-bit colour, 0 during blanking
//   blank_n     : high while the output pixel is visible
//   frame_start : one-cycle pulse aligned with output pixel (0,0)
// ---------------------------------------------------------------------------
module vga_canvas_reader
  import vga_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] colorCode,
  output logic [9:0] rx,
  output logic [9:0] ry,
  output logic       hsync,
  output logic       vsync,
  output logic [3:0] r,
  output logic [3:0] g,
  output logic [3:0] b,
  output logic       blank_n,
  output logic       frame_start
);

  logic [9:0] hcnt, vcnt;
  logic       active, hsync_raw, vsync_raw, sof;

  vga_timing u_timing (
    .clk       (clk),
    .reset     (reset),
    .hcnt      (hcnt),
    .vcnt      (vcnt),
    .active    (active),
    .hsync_raw (hsync_raw),
    .vsync_raw (vsync_raw),
    .sof       (sof)
  );

  // Stage 0: canvas window. The address is forced to 0 outside the window so
  // the store never sees an out-of-range coordinate.
  logic in_canvas;

  assign in_canvas = (hcnt >= CANVAS_X0) && (hcnt < CANVAS_X0 + CANVAS_W) &&
                     (vcnt >= CANVAS_Y0) && (vcnt < CANVAS_Y0 + CANVAS_H);
  assign rx = in_canvas ? hcnt - CANVAS_X0 : '0;
  assign ry = in_canvas ? vcnt - CANVAS_Y0 : '0;

  // Stage 1: delay the control flags to line up with the store's read data.
  logic in_canvas_d1, active_d1, hsync_d1, vsync_d1, sof_d1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      in_canvas_d1 <= 1'b0;
      active_d1    <= 1'b0;
      hsync_d1     <= 1'b1;
      vsync_d1     <= 1'b1;
      sof_d1       <= 1'b0;
    end else begin
      in_canvas_d1 <= in_canvas;
      active_d1    <= active;
      hsync_d1     <= hsync_raw;
      vsync_d1     <= vsync_raw;
      sof_d1       <= sof;
    end
  end

  // Palette lookup feeding the output registers.
  rgb_t pix;

  // NOTE: the default assignment up front keeps this block free of latches.
  always_comb begin
    pix = '0;
    if (in_canvas_d1)   pix = PALETTE[colorCode];
    else if (active_d1) pix = PALETTE[BORDER_CODE];
  end

  // Stage 2: every pin is registered here so sync, blank and colour stay aligned.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hsync       <= 1'b1;
      vsync       <= 1'b1;
      r           <= '0;
      g           <= '0;
      b           <= '0;
      blank_n     <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      hsync       <= hsync_d1;
      vsync       <= vsync_d1;
      r           <= pix.r;
      g           <= pix.g;
      b           <= pix.b;
      blank_n     <= active_d1;
      frame_start <= sof_d1;
    end
  end

endmodule

// File: tb/tb_vga_canvas_reader.sv
// ---------------------------------------------------------------------------
// tb_vga_canvas_reader
//   Scoreboard bench: directed screen positions are queued with their
//   hand-computed expected address/colour and the cycle they must appear;
//   a negedge monitor pops and compares. Sync/frame statistics are gathered
//   alongside and checked at the end.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_vga_canvas_reader;

  localparam int LINE = 800;
  localparam logic [63:0] RST_EXP = 64'h0000_000C_0000_0000;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [2:0] color_code = 3'd0;
  logic [9:0] rx, ry;
  logic       hsync, vsync, blank_n, frame_start;
  logic [3:0] r, g, b;

  vga_canvas_reader dut (
    .clk         (clk),
    .reset       (reset),
    .colorCode   (color_code),
    .rx          (rx),
    .ry          (ry),
    .hsync       (hsync),
    .vsync       (vsync),
    .r           (r),
    .g           (g),
    .b           (b),
    .blank_n     (blank_n),
    .frame_start (frame_start)
  );

  always #20 clk = ~clk;

  // Pixel store model: 1-cycle registered read, code = {ry[0], rx[1:0]}.
  always @(posedge clk) color_code <= {ry[0], rx[1:0]};

  // Rising edges since the last reset release.
  int cyc = 0;
  always @(posedge clk or posedge reset)
    if (reset) cyc <= 0;
    else       cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (cyc %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [63:0] rst_vec();
    return 64'({hsync, vsync, blank_n, frame_start, r, g, b, rx, ry});
  endfunction

  // ---------------- scoreboard ----------------
  typedef enum {K_ADDR, K_PIX, K_FS} kind_t;
  typedef struct {
    int         due;
    kind_t      kind;
    string      name;
    logic [63:0] exp;
  } exp_t;

  exp_t sb[$];

  task automatic push(input exp_t e);
    int i = 0;
    while (i < sb.size() && sb[i].due <= e.due) i++;
    sb.insert(i, e);
  endtask

  task automatic push_addr(input string name, input int h, input int v, input int erx, input int ery);
    exp_t e;
    e.due = v * LINE + h; e.kind = K_ADDR; e.name = name;
    e.exp = 64'({10'(erx), 10'(ery)});
    push(e);
  endtask

  task automatic push_pix(input string name, input int h, input int v, input logic eb, input logic [11:0] ergb);
    exp_t e;
    e.due = v * LINE + h + 2; e.kind = K_PIX; e.name = name;
    e.exp = 64'({eb, ergb});
    push(e);
  endtask

  task automatic push_fs(input string name, input int due, input logic efs);
    exp_t e;
    e.due = due; e.kind = K_FS; e.name = name; e.exp = 64'(efs);
    push(e);
  endtask

  exp_t mon_e;
  always @(negedge clk) begin
    if (!reset) begin
      while (sb.size() > 0 && sb[0].due <= cyc) begin
        mon_e = sb.pop_front();
        if (mon_e.due < cyc) begin
          n_cmp++; n_bad++;
          $display("FAIL %s: not sampled at cyc %0d (now %0d)", mon_e.name, mon_e.due, cyc);
        end else begin
          case (mon_e.kind)
            K_ADDR:  check(mon_e.name, 64'({rx, ry}), mon_e.exp);
            K_PIX:   check(mon_e.name, 64'({blank_n, r, g, b}), mon_e.exp);
            default: check(mon_e.name, 64'(frame_start), mon_e.exp);
          endcase
        end
      end
    end
  end

  // ---------------- sync / frame statistics ----------------
  logic hs_prev = 1'b1, vs_prev = 1'b1;
  int   hs_runs, hs_bad_len, hs_bad_per, hs_start;
  int   vs_runs, vs_start, vs_len;
  int   fs_times[$];

  always @(negedge clk) begin
    if (reset) begin
      hs_prev = 1'b1; vs_prev = 1'b1;
      hs_runs = 0; hs_bad_len = 0; hs_bad_per = 0; hs_start = 0;
      vs_runs = 0; vs_start = 0; vs_len = 0;
      fs_times.delete();
    end else begin
      if (frame_start) fs_times.push_back(cyc);
      if (!hsync && hs_prev) begin
        if (hs_runs > 0 && cyc - hs_start != LINE) hs_bad_per++;
        hs_start = cyc;
        hs_runs++;
      end
      if (hsync && !hs_prev && cyc - hs_start != 96) hs_bad_len++;
      if (!vsync && vs_prev) begin
        vs_start = cyc;
        vs_runs++;
      end
      if (vsync && !vs_prev) vs_len = cyc - vs_start;
      hs_prev = hsync;
      vs_prev = vsync;
    end
  end

  task automatic wait_cyc(input int target, input int budget);
    int n = 0;
    while (cyc < target && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (cyc != target) begin
      n_cmp++; n_bad++;
      $display("FAIL wait_cyc: reached %0d, wanted %0d", cyc, target);
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    #5 reset = 1'b1;
    repeat (5) begin
      @(negedge clk);
      check("rst_hold", rst_vec(), RST_EXP);
    end

    // First frame: borders, blanking, line-start alignment, canvas top rows.
    push_fs  ("fs_first",      2,        1'b1);
    push_addr("addr_100_100",  100, 100, 0,   0);
    push_pix ("pix_100_100",   100, 100, 1'b1, 12'h000);
    push_pix ("pix_700_100",   700, 100, 1'b0, 12'h000);
    push_pix ("pix_799_139",   799, 139, 1'b0, 12'h000);
    push_pix ("pix_0_140",     0,   140, 1'b1, 12'h000);
    push_addr("addr_219_140",  219, 140, 0,   0);
    push_addr("addr_220_140",  220, 140, 0,   0);
    push_pix ("pix_220_140",   220, 140, 1'b1, 12'h000);
    push_addr("addr_221_140",  221, 140, 1,   0);
    push_pix ("pix_221_140",   221, 140, 1'b1, 12'hF00);
    push_pix ("pix_222_140",   222, 140, 1'b1, 12'h0F0);
    push_pix ("pix_223_140",   223, 140, 1'b1, 12'h00F);
    push_addr("addr_419_140",  419, 140, 199, 0);
    push_pix ("pix_419_140",   419, 140, 1'b1, 12'h00F);
    push_addr("addr_420_140",  420, 140, 0,   0);
    push_pix ("pix_420_140",   420, 140, 1'b1, 12'h000);
    push_pix ("pix_220_141",   220, 141, 1'b1, 12'hFF0);
    push_pix ("pix_221_141",   221, 141, 1'b1, 12'h0FF);
    push_pix ("pix_222_141",   222, 141, 1'b1, 12'hF0F);
    push_pix ("pix_223_141",   223, 141, 1'b1, 12'hFFF);

    reset = 1'b0;

    // Mid-frame reset at hcnt=300, vcnt=200.
    wait_cyc(200 * LINE + 300, 170000);
    check("pre_rst_addr", 64'({rx, ry}), 64'({10'd80, 10'd60}));
    check("pre_rst_pix",  64'({blank_n, r, g, b}), 64'h10F0);
    reset = 1'b1;
    #1;
    check("rst_async", rst_vec(), RST_EXP);
    repeat (3) begin
      @(negedge clk);
      check("rst_mid_hold", rst_vec(), RST_EXP);
    end

    // Restarted frame: first frame_start on the 3rd edge, canvas bottom edge.
    push_fs  ("fs_edge1",      1,        1'b0);
    push_fs  ("fs_edge2",      2,        1'b1);
    push_fs  ("fs_edge3",      3,        1'b0);
    push_addr("addr_419_339",  419, 339, 199, 199);
    push_pix ("pix_419_339",   419, 339, 1'b1, 12'hFFF);
    push_addr("addr_220_340",  220, 340, 0,   0);
    push_pix ("pix_220_340",   220, 340, 1'b1, 12'h000);
    push_pix ("pix_0_480",     0,   480, 1'b0, 12'h000);

    reset = 1'b0;
    wait_cyc(420010, 430000);

    check("fs_count", 64'(fs_times.size()), 64'd2);
    if (fs_times.size() >= 2) begin
      check("fs_at",     64'(fs_times[0]), 64'd2);
      check("fs_period", 64'(fs_times[1] - fs_times[0]), 64'd420000);
    end
    check("hs_runs",    64'(hs_runs),    64'd525);
    check("hs_bad_len", 64'(hs_bad_len), 64'd0);
    check("hs_bad_per", 64'(hs_bad_per), 64'd0);
    check("vs_runs",    64'(vs_runs),    64'd1);
    check("vs_start",   64'(vs_start),   64'd392002);
    check("vs_len",     64'(vs_len),     64'd1600);
    check("sb_drained", 64'(sb.size()),  64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
